prpg_gen: RTL

PRPG_GEN -- requirements
Module: prpg_gen

---
 rtl/prpg_pkg.sv | 22 ++
 rtl/prpg_next.sv | 39 +++
 rtl/prpg_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/prpg_pkg.sv
// prpg_pkg: shared types and constants for the pseudo-random pattern generator.
//   state_t  : run-control FSM states (IDLE, RUN, DONE)
//   mode_t   : pattern generator selection (LFSR or cellular automaton)
//   DEF_TAPS : default 4-bit LFSR feedback tap mask
//   DEF_RULE : default 4-bit CA rule vector (1 = rule 150, 0 = rule 90)
package prpg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_LFSR = 1'b0,
        MODE_CA   = 1'b1
    } mode_t;

    localparam logic [3:0] DEF_TAPS = 4'b1100;
    localparam logic [3:0] DEF_RULE = 4'b0101;

endpackage

// File: rtl/prpg_next.sv
// prpg_next: purely combinational next-state function of the generator.
//   i_state : current W-bit state
//   i_mode  : 0 = LFSR shift-left with XOR feedback, 1 = 90/150 cellular automaton
//   i_taps  : LFSR feedback tap mask (bit i set -> state[i] feeds back)
//   i_rule  : CA rule vector (bit i set -> cell i also XORs itself, rule 150)
//   o_next  : next state
module prpg_next
    import prpg_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_state,
    input  logic         i_mode,
    input  logic [W-1:0] i_taps,
    input  logic [W-1:0] i_rule,
    output logic [W-1:0] o_next
);

    logic [W-1:0] w_lfsr;
    logic [W-1:0] w_ca;

    assign w_lfsr = {i_state[W-2:0], ^(i_state & i_taps)};

    // Cells beyond either end of the register read as zero (null boundary).
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_ca
            if (gi == 0) begin : g_lo
                assign w_ca[gi] = i_state[gi+1] ^ (i_rule[gi] & i_state[gi]);
            end else if (gi == W-1) begin : g_hi
                assign w_ca[gi] = i_state[gi-1] ^ (i_rule[gi] & i_state[gi]);
            end else begin : g_mid
                assign w_ca[gi] = i_state[gi-1] ^ i_state[gi+1] ^ (i_rule[gi] & i_state[gi]);
            end
        end
    endgenerate

    assign o_next = (mode_t'(i_mode) == MODE_CA) ? w_ca : w_lfsr;

endmodule

// File: rtl/prpg_gen.sv
// prpg_gen: pseudo-random pattern generator with run control and optional MISR.
//   clk, rst  : clock (rising edge) and synchronous active-high reset
//   start_i   : start a run (sampled only in IDLE); mode_i/seed_i/count_i latched then
//   en_i      : advance enable during RUN (low stalls)
//   resp_i    : circuit-under-test response compacted into the signature
//   pat_o     : current pattern; valid_o marks counted patterns
//   busy_o    : high in RUN and DONE; done_o: one-cycle end-of-run pulse
//   sig_o     : MISR signature
// Optional feature: define PRPG_SIG_EN to build the MISR; otherwise sig_o is 0.
module prpg_gen
    import prpg_pkg::*;
#(
    parameter int             W    = 4,
    parameter int             CW   = 8,
    parameter logic [W-1:0]   TAPS = W'(DEF_TAPS),
    parameter logic [W-1:0]   RULE = W'(DEF_RULE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [W-1:0]  seed_i,
    input  logic [CW-1:0] count_i,
    input  logic          en_i,
    input  logic [W-1:0]  resp_i,
    output logic [W-1:0]  pat_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  sig_o
);

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_pat;
    logic [W-1:0]  w_pat_next;
    logic [CW-1:0] r_cnt;      // patterns still to be emitted in this run
    logic          r_mode;
    logic          w_start_ok;
    logic          w_valid;
    logic          w_last;

    assign w_start_ok = (r_state == ST_IDLE) && start_i;
    assign w_valid    = (r_state == ST_RUN) && en_i;
    assign w_last     = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = (count_i != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_valid && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The last pattern is not advanced so pat_o keeps showing it until the
    // next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_start_ok) begin
            r_pat  <= (seed_i == '0) ? W'(1) : seed_i;
            r_cnt  <= count_i;
            r_mode <= mode_i;
        end else if (w_valid) begin
            r_cnt <= r_cnt - CW'(1);
            if (!w_last) begin
                r_pat <= w_pat_next;
            end
        end
    end

    prpg_next #(.W(W)) u_next (
        .i_state (r_pat),
        .i_mode  (r_mode),
        .i_taps  (TAPS),
        .i_rule  (RULE),
        .o_next  (w_pat_next)
    );

    assign pat_o   = r_pat;
    assign valid_o = w_valid;
    assign busy_o  = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done_o  = (r_state == ST_DONE);

`ifdef PRPG_SIG_EN
    logic [W-1:0] r_sig;
    logic [W-1:0] w_sig_shift;

    // MISR = the LFSR step of the signature with the response folded in.
    prpg_next #(.W(W)) u_misr (
        .i_state (r_sig),
        .i_mode  (MODE_LFSR),
        .i_taps  (TAPS),
        .i_rule  (RULE),
        .o_next  (w_sig_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else if (w_start_ok) begin
            r_sig <= '0;
        end else if (w_valid) begin
            r_sig <= w_sig_shift ^ resp_i;
        end
    end

    assign sig_o = r_sig;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^resp_i;
    assign sig_o         = '0;
`endif

endmodule
